ccr_unit: RTL and testbench
===========================

Name: ccr_unit

Overview:
Execute-stage condition-code register. It consumes the 3-bit flag vector produced by the ALU in the same cycle and holds the architectural flags. It resolves SETC/CLRC and the flag-conditional jumps JZ/JN/JC, clearing the tested flag when a jump is taken. It also saves and restores flags across interrupt entry and RTI through a small internal LIFO.

Parameters:
CCR_W, 3, flag vector width; bit 0 = Z, bit 1 = N, bit 2 = C.
SAVE_DEPTH, 2, number of nested interrupt flag snapshots held; must be at least 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
alu_ccr  in  CCR_W  flags from the ALU for the instruction currently in EX.
alu_wr  in  1  the EX instruction writes flags.
flag_mask  in  CCR_W  per-flag write enable, qualified by alu_wr (e.g. ADD = 3'b111, AND = 3'b011).
setc  in  1  set C.
clrc  in  1  clear C.
jz  in  1  JZ in EX.
jn  in  1  JN in EX.
jc  in  1  JC in EX.
int_save  in  1  interrupt entry; push the current flags.
rti_restore  in  1  RTI; pop the saved flags.
stall  in  1  hold all state.
flush  in  1  squash the EX instruction.
ccr_out  out  CCR_W  registered architectural flags.
branch_taken  out  1  combinational conditional-jump decision.
stack_cnt  out  $clog2(SAVE_DEPTH+1)  number of occupied LIFO entries.

Behaviour:
- Reset: ccr_out = 0; LIFO emptied; stack_cnt = 0. branch_taken is 0 while the flags are 0.
- branch_taken = (jz & ccr_out[0]) | (jn & ccr_out[1]) | (jc & ccr_out[2]).
  - Uses the registered flags only: the producing instruction has already committed one cycle earlier, so no bypass is needed.
  - Forced to 0 when flush or stall is high.
- Next-state priority, highest first:
  1. rst
  2. stall: hold everything
  3. flush: hold everything
  4. rti_restore
  5. int_save
  6. instruction update
- rti_restore:
  - LIFO not empty: ccr_out <= top entry; stack_cnt decrements.
  - LIFO empty (underflow): ccr_out holds; stack_cnt stays 0.
- int_save:
  - LIFO not full: push ccr_out; stack_cnt increments; ccr_out unchanged.
  - LIFO full (overflow): push ignored; ccr_out and LIFO unchanged.
- int_save and rti_restore asserted together: the restore is performed and the save is dropped.
- Instruction update, applied per flag bit i:
  - alu_wr & flag_mask[i] → ccr_out[i] <= alu_ccr[i].
  - Else a taken jump that tested bit i → bit i <= 0 (JZ clears Z, JN clears N, JC clears C).
  - Else for bit 2 only: setc → 1, clrc → 0; setc and clrc together → 1.
  - Otherwise the bit holds.
- Multiple jump strobes in one cycle: each taken condition clears its own flag.
- Latency:
  - ALU flags are visible on ccr_out one cycle after alu_wr.
  - A restore is visible the next cycle.
  - A snapshot taken by int_save contains the flags as they stand before that cycle's edge.
- No X propagation: alu_ccr is ignored unless alu_wr is high.

Optional Feature:
CCR_STACK_ERR_EN.
- Defined: adds outputs err_ovf and err_udf and input err_clr.
  - err_ovf sets on a push while the LIFO is full; err_udf sets on a pop while it is empty.
  - Both are sticky until err_clr or rst, and clear the cycle after.
  - err_clr and a new error in the same cycle: the error wins.
- Not defined: these ports are absent; overflow and underflow are silently ignored as described above.

Decomposition:
- Package ccr_pkg:
  - CCR_W.
  - Flag index constants FLAG_Z = 0, FLAG_N = 1, FLAG_C = 2.
  - Mask constants MASK_ALL = 3'b111, MASK_ZN = 3'b011.
  - Typedef ccr_t.
- Sub-module ccr_stack: parameterised LIFO (SAVE_DEPTH x CCR_W) with push, pop, full, empty and count. ccr_unit instantiates one copy.

Test Plan:
1. Reset, then alu_wr = 1, mask = 111, alu_ccr = 3'b101 → next cycle ccr_out = 101. Then a JZ with no other flag activity → branch_taken = 1 and ccr_out = 100 the following cycle.
2. ccr_out = 000: assert setc → 100. Next cycle assert setc and clrc together → stays 100. Next cycle assert clrc alone → 000.
3. ccr_out = 110, alu_wr = 1, mask = 011, alu_ccr = 001 → ccr_out = 101 (C preserved).
4. Nested interrupts: ccr_out = 011, int_save; ccr_out = 100, int_save → stack_cnt = 2. Third int_save → stack_cnt stays 2 (err_ovf = 1 with CCR_STACK_ERR_EN). Two rti_restore pulses → ccr_out = 100, then 011; stack_cnt = 0.
5. stack_cnt = 0, rti_restore → ccr_out unchanged (err_udf = 1 with the macro; cleared by err_clr next cycle).
6. ccr_out = 001, jz with stall = 1 → branch_taken = 0, ccr_out stays 001. Same with flush = 1 → identical result. Then jz alone → branch_taken = 1, ccr_out = 000.

Source files
------------

// File: rtl/ccr_pkg.sv
// Shared definitions for the execute-stage condition-code register: flag layout,
// common write masks and the flag vector type.
package ccr_pkg;

    localparam int CCR_W  = 3;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    localparam logic [CCR_W-1:0] MASK_ALL = 3'b111;
    localparam logic [CCR_W-1:0] MASK_ZN  = 3'b011;

    typedef logic [CCR_W-1:0] ccr_t;

endpackage

// File: rtl/ccr_stack.sv
// LIFO of flag snapshots used across nested interrupts; push is ignored when
// full, pop is ignored when empty, and push takes precedence if both are asserted.
module ccr_stack #(
    parameter int DEPTH = 2,
    parameter int W     = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [W-1:0]     dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    // Storage is rounded up to a power of two so the count indexes it at full width.
    localparam int SLOTS = 1 << CNT_W;

    logic [W-1:0]     mem_q [SLOTS];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] top_idx;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign top_idx = cnt_q - CNT_W'(1);
    assign dout_o  = mem_q[top_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (push_i && !full_o) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[cnt_q] <= din_i;
        end
    end

endmodule

// File: rtl/ccr_unit.sv
// Execute-stage condition-code register with SETC/CLRC, flag-clearing conditional
// jumps and interrupt save/restore. Define CCR_STACK_ERR_EN for sticky LIFO error flags.
module ccr_unit
    import ccr_pkg::*;
#(
    parameter int SAVE_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CCR_W-1:0]                alu_ccr,
    input  logic                            alu_wr,
    input  logic [CCR_W-1:0]                flag_mask,
    input  logic                            setc,
    input  logic                            clrc,
    input  logic                            jz,
    input  logic                            jn,
    input  logic                            jc,
    input  logic                            int_save,
    input  logic                            rti_restore,
    input  logic                            stall,
    input  logic                            flush,
`ifdef CCR_STACK_ERR_EN
    input  logic                            err_clr,
    output logic                            err_ovf,
    output logic                            err_udf,
`endif
    output logic [CCR_W-1:0]                ccr_out,
    output logic                            branch_taken,
    output logic [$clog2(SAVE_DEPTH+1)-1:0] stack_cnt
);

    localparam int CNT_W = $clog2(SAVE_DEPTH + 1);

    ccr_t ccr_q, ccr_d;
    ccr_t jump_clr;
    ccr_t stk_top;
    logic hold;
    logic do_pop, do_push;
    logic stk_full, stk_empty;

    assign hold    = stall | flush;
    assign do_pop  = !hold && rti_restore;
    assign do_push = !hold && !rti_restore && int_save;

    // Each taken jump clears exactly the flag it tested.
    assign jump_clr[FLAG_Z] = jz & ccr_q[FLAG_Z];
    assign jump_clr[FLAG_N] = jn & ccr_q[FLAG_N];
    assign jump_clr[FLAG_C] = jc & ccr_q[FLAG_C];

    assign branch_taken = !hold && (|jump_clr);
    assign ccr_out      = ccr_q;

    ccr_stack #(
        .DEPTH (SAVE_DEPTH),
        .W     (CCR_W),
        .CNT_W (CNT_W)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (do_push),
        .pop_i   (do_pop),
        .din_i   (ccr_q),
        .dout_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .count_o (stack_cnt)
    );

    always_comb begin
        ccr_d = ccr_q;
        if (hold) begin
            ccr_d = ccr_q;
        end else if (rti_restore) begin
            if (!stk_empty) begin
                ccr_d = stk_top;
            end
        end else if (!int_save) begin
            for (int i = 0; i < CCR_W; i++) begin
                if (alu_wr && flag_mask[i]) begin
                    ccr_d[i] = alu_ccr[i];
                end else if (jump_clr[i]) begin
                    ccr_d[i] = 1'b0;
                end else if (i == FLAG_C) begin
                    if (setc) begin
                        ccr_d[i] = 1'b1;
                    end else if (clrc) begin
                        ccr_d[i] = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_q <= '0;
        end else begin
            ccr_q <= ccr_d;
        end
    end

`ifdef CCR_STACK_ERR_EN
    logic err_ovf_q, err_udf_q;

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (do_push && stk_full) begin
                err_ovf_q <= 1'b1;
            end else if (err_clr) begin
                err_ovf_q <= 1'b0;
            end
            if (do_pop && stk_empty) begin
                err_udf_q <= 1'b1;
            end else if (err_clr) begin
                err_udf_q <= 1'b0;
            end
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule

// File: tb/tb_ccr_unit.sv
// Bench for ccr_unit: directed vector table, error-flag sequence and a randomized
// run checked against a queue-based reference model.
module tb_ccr_unit;
    import ccr_pkg::*;

    localparam int SAVE_DEPTH = 2;
    localparam int CNT_W      = $clog2(SAVE_DEPTH + 1);

    localparam logic [8:0] C_NONE  = 9'h000;
    localparam logic [8:0] C_REST  = 9'h001;
    localparam logic [8:0] C_SAVE  = 9'h002;
    localparam logic [8:0] C_JC    = 9'h004;
    localparam logic [8:0] C_JN    = 9'h008;
    localparam logic [8:0] C_JZ    = 9'h010;
    localparam logic [8:0] C_CLRC  = 9'h020;
    localparam logic [8:0] C_SETC  = 9'h040;
    localparam logic [8:0] C_FLUSH = 9'h080;
    localparam logic [8:0] C_STALL = 9'h100;

    typedef struct {
        logic [2:0]       ac;
        logic             wr;
        logic [2:0]       mk;
        logic [8:0]       ctl;
        logic             bt;
        logic [2:0]       ccr;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [2:0]       alu_ccr, flag_mask;
    logic             alu_wr, setc, clrc, jz, jn, jc;
    logic             int_save, rti_restore, stall, flush;
    logic [2:0]       ccr_out;
    logic             branch_taken;
    logic [CNT_W-1:0] stack_cnt;
`ifdef CCR_STACK_ERR_EN
    logic             err_clr, err_ovf, err_udf;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ccr_unit #(.SAVE_DEPTH(SAVE_DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_ccr      (alu_ccr),
        .alu_wr       (alu_wr),
        .flag_mask    (flag_mask),
        .setc         (setc),
        .clrc         (clrc),
        .jz           (jz),
        .jn           (jn),
        .jc           (jc),
        .int_save     (int_save),
        .rti_restore  (rti_restore),
        .stall        (stall),
        .flush        (flush),
`ifdef CCR_STACK_ERR_EN
        .err_clr      (err_clr),
        .err_ovf      (err_ovf),
        .err_udf      (err_udf),
`endif
        .ccr_out      (ccr_out),
        .branch_taken (branch_taken),
        .stack_cnt    (stack_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [2:0] ac, input logic wr, input logic [2:0] mk,
                               input logic [8:0] ctl, input logic bt, input logic [2:0] ccr,
                               input logic [CNT_W-1:0] cnt);
        vec_t r;
        r.ac = ac; r.wr = wr; r.mk = mk; r.ctl = ctl;
        r.bt = bt; r.ccr = ccr; r.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic [2:0] ac, input logic wr, input logic [2:0] mk, input logic [8:0] ctl);
        alu_ccr     = ac;
        alu_wr      = wr;
        flag_mask   = mk;
        rti_restore = ctl[0];
        int_save    = ctl[1];
        jc          = ctl[2];
        jn          = ctl[3];
        jz          = ctl[4];
        clrc        = ctl[5];
        setc        = ctl[6];
        flush       = ctl[7];
        stall       = ctl[8];
    endtask

    task automatic apply(input vec_t t, input string tag);
        @(negedge clk);
        drive(t.ac, t.wr, t.mk, t.ctl);
        #1;
        chk({tag, ".branch_taken"}, 32'(branch_taken), 32'(t.bt));
        @(posedge clk);
        #1;
        chk({tag, ".ccr_out"}, 32'(ccr_out), 32'(t.ccr));
        chk({tag, ".stack_cnt"}, 32'(stack_cnt), 32'(t.cnt));
    endtask

    vec_t       tbl[$];
    logic [2:0] m_ccr;
    logic [2:0] m_stk[$];

    initial begin
        rst = 1'b1;
        drive(3'b000, 1'b0, 3'b000, C_NONE);
`ifdef CCR_STACK_ERR_EN
        err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset.ccr_out", 32'(ccr_out), 32'd0);
        chk("reset.stack_cnt", 32'(stack_cnt), 32'd0);
`ifdef CCR_STACK_ERR_EN
        chk("reset.err_ovf", 32'(err_ovf), 32'd0);
        chk("reset.err_udf", 32'(err_udf), 32'd0);
`endif

        tbl.push_back(v(3'b000, 0, 3'b000, C_JZ | C_JN | C_JC, 0, 3'b000, 0));
        tbl.push_back(v(3'b101, 1, MASK_ALL, C_NONE,           0, 3'b101, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_JZ,               1, 3'b100, 0));
        tbl.push_back(v(3'b000, 1, MASK_ALL, C_NONE,           0, 3'b000, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_SETC,             0, 3'b100, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_SETC | C_CLRC,    0, 3'b100, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_CLRC,             0, 3'b000, 0));
        tbl.push_back(v(3'b110, 1, MASK_ALL, C_NONE,           0, 3'b110, 0));
        tbl.push_back(v(3'b001, 1, MASK_ZN,  C_NONE,           0, 3'b101, 0));
        tbl.push_back(v(3'b011, 1, MASK_ALL, C_NONE,           0, 3'b011, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_SAVE,             0, 3'b011, 1));
        tbl.push_back(v(3'b100, 1, MASK_ALL, C_NONE,           0, 3'b100, 1));
        tbl.push_back(v(3'b000, 0, 3'b000, C_SAVE,             0, 3'b100, 2));
        tbl.push_back(v(3'b000, 0, 3'b000, C_SAVE,             0, 3'b100, 2));
        tbl.push_back(v(3'b000, 0, 3'b000, C_REST,             0, 3'b100, 1));
        tbl.push_back(v(3'b000, 0, 3'b000, C_REST,             0, 3'b011, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_REST,             0, 3'b011, 0));
        tbl.push_back(v(3'b001, 1, MASK_ALL, C_NONE,           0, 3'b001, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_JZ | C_STALL,     0, 3'b001, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_JZ | C_FLUSH,     0, 3'b001, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_JZ,               1, 3'b000, 0));
        tbl.push_back(v(3'b111, 1, MASK_ALL, C_NONE,           0, 3'b111, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_JZ | C_JN | C_JC, 1, 3'b000, 0));
        tbl.push_back(v(3'b110, 1, MASK_ALL, C_NONE,           0, 3'b110, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_SAVE | C_REST,    0, 3'b110, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_SAVE,             0, 3'b110, 1));
        tbl.push_back(v(3'b001, 1, MASK_ALL, C_NONE,           0, 3'b001, 1));
        tbl.push_back(v(3'b000, 0, 3'b000, C_SAVE | C_REST,    0, 3'b110, 0));
        tbl.push_back(v(3'b111, 0, MASK_ALL, C_NONE,           0, 3'b110, 0));
        tbl.push_back(v(3'b010, 1, 3'b010, C_JN,               1, 3'b110, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_JN,               1, 3'b100, 0));
        tbl.push_back(v(3'b011, 1, MASK_ALL, C_STALL | C_SAVE, 0, 3'b100, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_FLUSH | C_CLRC,   0, 3'b100, 0));
        tbl.push_back(v(3'b000, 1, MASK_ALL, C_SETC,           0, 3'b000, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_JC | C_SETC,      0, 3'b100, 0));
        tbl.push_back(v(3'b000, 0, 3'b000, C_JC | C_SETC,      1, 3'b000, 0));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

`ifdef CCR_STACK_ERR_EN
        apply(v(3'b000, 0, 3'b000, C_SAVE, 0, 3'b000, 1), "err_save1");
        apply(v(3'b000, 0, 3'b000, C_SAVE, 0, 3'b000, 2), "err_save2");
        chk("err_ovf_before", 32'(err_ovf), 32'd0);
        apply(v(3'b000, 0, 3'b000, C_SAVE, 0, 3'b000, 2), "err_save3");
        chk("err_ovf_set", 32'(err_ovf), 32'd1);
        @(negedge clk); err_clr = 1'b1;
        apply(v(3'b000, 0, 3'b000, C_NONE, 0, 3'b000, 2), "err_clr_ovf");
        chk("err_ovf_cleared", 32'(err_ovf), 32'd0);
        @(negedge clk); err_clr = 1'b0;
        apply(v(3'b000, 0, 3'b000, C_REST, 0, 3'b000, 1), "err_rest1");
        apply(v(3'b000, 0, 3'b000, C_REST, 0, 3'b000, 0), "err_rest2");
        chk("err_udf_before", 32'(err_udf), 32'd0);
        apply(v(3'b000, 0, 3'b000, C_REST, 0, 3'b000, 0), "err_rest3");
        chk("err_udf_set", 32'(err_udf), 32'd1);
        @(negedge clk); err_clr = 1'b1;
        apply(v(3'b000, 0, 3'b000, C_REST, 0, 3'b000, 0), "err_clr_vs_new");
        chk("err_udf_error_wins", 32'(err_udf), 32'd1);
        apply(v(3'b000, 0, 3'b000, C_NONE, 0, 3'b000, 0), "err_clr_udf");
        chk("err_udf_cleared", 32'(err_udf), 32'd0);
        @(negedge clk); err_clr = 1'b0;
`endif

        // Randomized run: model state is the flags plus a plain queue of snapshots.
        m_ccr = ccr_out;
        m_stk.delete();
        for (int k = 0; k < int'(stack_cnt); k++) m_stk.push_back(3'b000);
        if (stack_cnt != 0) begin
            rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
            m_ccr = 3'b000; m_stk.delete();
        end
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] ac, mk, nm, taken;
            logic       wr, r_rst, exp_bt;
            logic [8:0] ctl;
            @(negedge clk);
            ac = 3'($urandom);
            mk = 3'($urandom);
            wr = ($urandom_range(0, 1) == 1);
            ctl = C_NONE;
            if ($urandom_range(0, 3) == 0) ctl |= C_SETC;
            if ($urandom_range(0, 3) == 0) ctl |= C_CLRC;
            if ($urandom_range(0, 2) == 0) ctl |= C_JZ;
            if ($urandom_range(0, 2) == 0) ctl |= C_JN;
            if ($urandom_range(0, 2) == 0) ctl |= C_JC;
            if ($urandom_range(0, 5) == 0) ctl |= C_SAVE;
            if ($urandom_range(0, 5) == 0) ctl |= C_REST;
            if ($urandom_range(0, 9) == 0) ctl |= C_STALL;
            if ($urandom_range(0, 9) == 0) ctl |= C_FLUSH;
            r_rst = ($urandom_range(0, 199) == 0);
            rst = r_rst;
            drive(ac, wr, mk, ctl);

            exp_bt = !(stall || flush) &&
                     ((jz && m_ccr[0]) || (jn && m_ccr[1]) || (jc && m_ccr[2]));
            #1;
            chk("rand.branch_taken", 32'(branch_taken), 32'(exp_bt));

            nm = m_ccr;
            if (r_rst) begin
                nm = 3'b000;
                m_stk.delete();
            end else if (stall || flush) begin
                nm = m_ccr;
            end else if (rti_restore) begin
                if (m_stk.size() > 0) nm = m_stk.pop_back();
            end else if (int_save) begin
                if (m_stk.size() < SAVE_DEPTH) m_stk.push_back(m_ccr);
            end else begin
                taken = {jc & m_ccr[2], jn & m_ccr[1], jz & m_ccr[0]};
                for (int b = 0; b < 3; b++) begin
                    if (wr && mk[b]) nm[b] = ac[b];
                    else if (taken[b]) nm[b] = 1'b0;
                    else if (b == 2 && (setc || clrc)) nm[b] = setc;
                end
            end
            m_ccr = nm;

            @(posedge clk);
            #1;
            chk("rand.ccr_out", 32'(ccr_out), 32'(m_ccr));
            chk("rand.stack_cnt", 32'(stack_cnt), 32'(m_stk.size()));
        end

        @(negedge clk);
        rst = 1'b0;
        drive(3'b000, 1'b0, 3'b000, C_NONE);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
